axis_skid_buffer: RTL and testbench
===================================

AXIS_SKID_BUFFER -- requirements
Module: axis_skid_buffer

Interface
REQ-001 SHALL provide parameter BYTE_WIDTH, default 4, TDATA width in bytes (TDATA = 8*BYTE_WIDTH bits, TKEEP = BYTE_WIDTH bits).
REQ-002 SHALL provide parameter USER_WIDTH, default 1, TUSER width in bits (minimum 1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tvalid  input  1  upstream beat valid.
REQ-006 s_tready  output  1  upstream accept, driven directly from a flop.
REQ-007 s_tdata  input  8*BYTE_WIDTH  upstream data.
REQ-008 s_tkeep  input  BYTE_WIDTH  upstream byte qualifier.
REQ-009 s_tlast  input  1  upstream packet end.
REQ-010 s_tuser  input  USER_WIDTH  upstream sideband.
REQ-011 m_tvalid / m_tready / m_tdata / m_tkeep / m_tlast / m_tuser  output/input/output/output/output/output  widths as s_*  downstream stream master; all outputs driven directly from flops.
REQ-012 beat_count  output  32  beats accepted downstream (present only with REQ-030).
REQ-013 pkt_count  output  32  packets completed downstream (present only with REQ-030).

Function
REQ-014 SHALL be a two-entry register slice: output register (OUT) plus skid register (SKID); states EMPTY, ONE (OUT valid), FULL (OUT and SKID valid).
REQ-015 s_tready SHALL be 1 in EMPTY and ONE, 0 in FULL; no combinational path from m_tready to s_tready or from s_* to m_*.
REQ-016 Upstream transfer = s_tvalid && s_tready; downstream transfer = m_tvalid && m_tready.
REQ-017 EMPTY + upstream transfer -> beat loaded into OUT, next state ONE; m_tvalid high next cycle (latency 1 cycle).
REQ-018 ONE + upstream only -> beat into SKID, next FULL; ONE + downstream only -> next EMPTY; ONE + both -> new beat into OUT, stay ONE.
REQ-019 FULL + downstream transfer -> SKID moves to OUT, next ONE; FULL + no downstream transfer -> hold, all m_* stable.
REQ-020 m_tvalid SHALL equal (state != EMPTY); while m_tvalid && !m_tready, m_tdata/m_tkeep/m_tlast/m_tuser SHALL be stable and m_tvalid SHALL NOT fall.
REQ-021 Beat order and all fields (tdata, tkeep, tlast, tuser) SHALL be preserved bit-exact; no beat dropped or duplicated.
REQ-022 Full throughput: with s_tvalid and m_tready held high, one beat per cycle after initial 1-cycle latency.
REQ-023 s_tready is registered, so it SHALL fall only on the transition into FULL, never between upstream assertion and acceptance of the same beat.

Reset
REQ-024 While reset is high: state EMPTY, m_tvalid = 0, s_tready = 0, counters = 0.
REQ-025 First cycle after reset deasserts: s_tready = 1, m_tvalid = 0.
REQ-026 Reset mid-operation SHALL discard OUT and SKID contents in the same edge; data register reset is not required (don't-care while m_tvalid = 0).
REQ-027 s_tvalid asserted during reset SHALL be ignored (no beat captured).

Configuration
REQ-028 Macro AXIS_SKID_PKT_COUNT_EN SHALL control the statistics counters.
REQ-029 Without macro: beat_count and pkt_count ports and logic absent; datapath per REQ-014..REQ-023.
REQ-030 With macro: beat_count increments by 1 per downstream transfer; pkt_count increments by 1 per downstream transfer with m_tlast = 1; both wrap 0xFFFFFFFF -> 0; registered, updated the cycle after the transfer; datapath timing unchanged.

Verification
REQ-031 Reset, then s_tvalid=1, tdata=0xA5A5A5A5, m_tready=1 -> m_tvalid=1 with 0xA5A5A5A5 exactly 1 cycle after acceptance.
REQ-032 Stream 0x1..0x8 with m_tready=1 throughout -> 8 consecutive output beats 0x1..0x8, no bubbles after first.
REQ-033 Send 0x10, 0x11 with m_tready=0 -> s_tready=0 after second accept, m_tdata holds 0x10; release m_tready -> 0x10 then 0x11 out, s_tready=1 again.
REQ-034 Random s_tvalid and m_tready (50%), 1000 beats, tkeep/tlast/tuser randomized -> output sequence identical to input; protocol stability properties (REQ-020) hold every cycle.
REQ-035 Assert reset for 1 cycle while FULL -> next cycle m_tvalid=0, s_tready=0; following cycle s_tready=1; stale beats never appear.
REQ-036 With AXIS_SKID_PKT_COUNT_EN: 3 packets of 4 beats -> beat_count=12, pkt_count=3; preload counters near 0xFFFFFFFF via 2^32-wrap test harness forcing -> wraps to 0.

Source files
------------

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice (output register + skid register), fully registered on both sides.
// Optional statistics counters (beat_count, pkt_count) are built only when AXIS_SKID_PKT_COUNT_EN is defined.
module axis_skid_buffer #(
   parameter int unsigned BYTE_WIDTH = 4,
   parameter int unsigned USER_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [8*BYTE_WIDTH-1:0] s_tdata,
   input  logic [BYTE_WIDTH-1:0]   s_tkeep,
   input  logic                    s_tlast,
   input  logic [USER_WIDTH-1:0]   s_tuser,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [8*BYTE_WIDTH-1:0] m_tdata,
   output logic [BYTE_WIDTH-1:0]   m_tkeep,
   output logic                    m_tlast,
   output logic [USER_WIDTH-1:0]   m_tuser
`ifdef AXIS_SKID_PKT_COUNT_EN
   ,
   output logic [31:0]             beat_count,
   output logic [31:0]             pkt_count
`endif
);

   localparam int unsigned DATA_W = 8 * BYTE_WIDTH;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;

   logic [DATA_W-1:0]     skid_tdata;
   logic [BYTE_WIDTH-1:0] skid_tkeep;
   logic                  skid_tlast;
   logic [USER_WIDTH-1:0] skid_tuser;

   logic up_xfer;
   logic dn_xfer;
   logic load_out_from_s;
   logic load_out_from_skid;
   logic load_skid;

   assign up_xfer = s_tvalid && s_tready;
   assign dn_xfer = m_tvalid && m_tready;

   // Datapath load enables derived from the current occupancy and both handshakes.
   always_comb begin
      load_out_from_s    = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid          = 1'b0;
      case (state)
         EMPTY: load_out_from_s = up_xfer;
         ONE: begin
            load_out_from_s = up_xfer && dn_xfer;
            load_skid       = up_xfer && !dn_xfer;
         end
         FULL:    load_out_from_skid = dn_xfer;
         default: ;
      endcase
   end

   // Occupancy FSM; s_tready and m_tvalid are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         m_tvalid <= 1'b0;
         s_tready <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               s_tready <= 1'b1;
               if (up_xfer) begin
                  state    <= ONE;
                  m_tvalid <= 1'b1;
               end
            end
            ONE: begin
               if (up_xfer && !dn_xfer) begin
                  state    <= FULL;
                  s_tready <= 1'b0;
               end else if (dn_xfer && !up_xfer) begin
                  state    <= EMPTY;
                  m_tvalid <= 1'b0;
               end
            end
            FULL: begin
               if (dn_xfer) begin
                  state    <= ONE;
                  s_tready <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               m_tvalid <= 1'b0;
               s_tready <= 1'b0;
            end
         endcase
      end
   end

   // Payload registers carry no reset; their contents are ignored while m_tvalid is low.
   always_ff @(posedge clk) begin
      if (load_out_from_s) begin
         m_tdata <= s_tdata;
         m_tkeep <= s_tkeep;
         m_tlast <= s_tlast;
         m_tuser <= s_tuser;
      end else if (load_out_from_skid) begin
         m_tdata <= skid_tdata;
         m_tkeep <= skid_tkeep;
         m_tlast <= skid_tlast;
         m_tuser <= skid_tuser;
      end
      if (load_skid) begin
         skid_tdata <= s_tdata;
         skid_tkeep <= s_tkeep;
         skid_tlast <= s_tlast;
         skid_tuser <= s_tuser;
      end
   end

`ifdef AXIS_SKID_PKT_COUNT_EN
   // Free-running wrap-around statistics of downstream transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_count <= 32'd0;
         pkt_count  <= 32'd0;
      end else if (dn_xfer) begin
         beat_count <= beat_count + 32'd1;
         if (m_tlast) begin
            pkt_count <= pkt_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Directed and randomized self-checking bench for axis_skid_buffer (default 4-byte data, 1-bit user).
// Counter checks are compiled only when AXIS_SKID_PKT_COUNT_EN is defined.
module tb_axis_skid_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tlast;
   logic [0:0]  s_tuser;
   logic        m_tvalid;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast;
   logic [0:0]  m_tuser;
`ifdef AXIS_SKID_PKT_COUNT_EN
   logic [31:0] beat_count;
   logic [31:0] pkt_count;
`endif

   int errors = 0;
   int checks = 0;

   axis_skid_buffer #(.BYTE_WIDTH(4), .USER_WIDTH(1)) dut (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser)
`ifdef AXIS_SKID_PKT_COUNT_EN
      , .beat_count(beat_count), .pkt_count(pkt_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sv;
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic        u;
      logic        mr;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
      logic        eu;
      logic        esr;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic sv, input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u, input logic mr,
                               input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                               input logic el, input logic eu, input logic esr);
      vec_t v;
      v.sv = sv; v.d = d; v.k = k; v.l = l; v.u = u; v.mr = mr;
      v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.eu = eu; v.esr = esr;
      return v;
   endfunction

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) step();
      reset = 1'b0;
   endtask

   logic [37:0] q[$];
   logic [37:0] cur;
   logic [37:0] held;
   logic [37:0] expb;
   logic        up;
   logic        dn;
   logic        hold;
   int          sent;
   int          recv;
   int          cyc;

   initial begin
      // Hand-computed per-cycle vectors; outputs are what must be visible after the edge.
      vecs[0] = mk(1, 32'hA5A5_A5A5, 4'hF, 0, 1, 1,  1, 32'hA5A5_A5A5, 4'hF, 0, 1, 1);
      vecs[1] = mk(0, 32'h0,         4'h0, 0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 1);
      vecs[2] = mk(1, 32'h10,        4'h3, 0, 0, 0,  1, 32'h10,        4'h3, 0, 0, 1);
      vecs[3] = mk(1, 32'h11,        4'hC, 1, 1, 0,  1, 32'h10,        4'h3, 0, 0, 0);
      vecs[4] = mk(1, 32'h12,        4'h1, 0, 0, 0,  1, 32'h10,        4'h3, 0, 0, 0);
      vecs[5] = mk(1, 32'h12,        4'h1, 0, 0, 1,  1, 32'h11,        4'hC, 1, 1, 1);
      vecs[6] = mk(1, 32'h12,        4'h1, 0, 0, 1,  1, 32'h12,        4'h1, 0, 0, 1);
      vecs[7] = mk(0, 32'h0,         4'h0, 0, 0, 0,  1, 32'h12,        4'h1, 0, 0, 1);
      vecs[8] = mk(0, 32'h0,         4'h0, 0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 1);

      s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF; s_tkeep = 4'hF; s_tlast = 1'b0;
      s_tuser = 1'b0; m_tready = 1'b1; reset = 1'b1;

      // Reset holds outputs low and ignores an asserted s_tvalid.
      for (int i = 0; i < 2; i++) begin
         step();
         chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
         chk("reset_s_tready", 64'(s_tready), 64'd0);
      end
      reset = 1'b0; s_tvalid = 1'b0;
      step();
      chk("post_reset_s_tready", 64'(s_tready), 64'd1);
      chk("post_reset_m_tvalid", 64'(m_tvalid), 64'd0);

      for (int i = 0; i < 9; i++) begin
         s_tvalid = vecs[i].sv; s_tdata = vecs[i].d; s_tkeep = vecs[i].k;
         s_tlast = vecs[i].l; s_tuser = vecs[i].u; m_tready = vecs[i].mr;
         step();
         chk($sformatf("vec%0d_m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].ev));
         chk($sformatf("vec%0d_s_tready", i), 64'(s_tready), 64'(vecs[i].esr));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_m_tdata", i), 64'(m_tdata), 64'(vecs[i].ed));
            chk($sformatf("vec%0d_m_tkeep", i), 64'(m_tkeep), 64'(vecs[i].ek));
            chk($sformatf("vec%0d_m_tlast", i), 64'(m_tlast), 64'(vecs[i].el));
            chk($sformatf("vec%0d_m_tuser", i), 64'(m_tuser), 64'(vecs[i].eu));
         end
      end

      // Back-to-back streaming with no bubbles after the first beat.
      m_tready = 1'b1; s_tkeep = 4'hF; s_tlast = 1'b0; s_tuser = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'(i);
         step();
         chk($sformatf("stream%0d_m_tvalid", i), 64'(m_tvalid), 64'd1);
         chk($sformatf("stream%0d_m_tdata", i), 64'(m_tdata), 64'(i));
         chk($sformatf("stream%0d_s_tready", i), 64'(s_tready), 64'd1);
      end
      s_tvalid = 1'b0;
      step();
      chk("stream_drain_m_tvalid", 64'(m_tvalid), 64'd0);

      // Reset while FULL discards both entries; a beat offered during reset is dropped.
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h20;
      step();
      s_tdata = 32'h21;
      step();
      chk("fill_s_tready", 64'(s_tready), 64'd0);
      chk("fill_m_tdata", 64'(m_tdata), 64'h20);
      s_tdata = 32'h22; reset = 1'b1;
      step();
      chk("rst_full_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_full_s_tready", 64'(s_tready), 64'd0);
      reset = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
      step();
      chk("rst_full_s_tready_after", 64'(s_tready), 64'd1);
      chk("rst_full_no_stale0", 64'(m_tvalid), 64'd0);
      step();
      chk("rst_full_no_stale1", 64'(m_tvalid), 64'd0);
      s_tvalid = 1'b1; s_tdata = 32'h30;
      step();
      chk("rst_full_new_m_tvalid", 64'(m_tvalid), 64'd1);
      chk("rst_full_new_m_tdata", 64'(m_tdata), 64'h30);
      s_tvalid = 1'b0;
      step();
      chk("rst_full_idle", 64'(m_tvalid), 64'd0);

      // Randomized traffic against a scoreboard queue with stall-stability checks.
      sent = 0; recv = 0; cyc = 0;
      cur = 38'({$urandom(), 6'($urandom())});
      {s_tdata, s_tkeep, s_tlast, s_tuser} = cur;
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      while (recv < 1000 && cyc < 20000) begin
         up = s_tvalid && s_tready;
         dn = m_tvalid && m_tready;
         if (dn) begin
            if (q.size() == 0) begin
               chk("rand_spurious_beat", 64'(m_tdata), 64'd0);
               expb = 38'd0;
            end else begin
               expb = q.pop_front();
            end
            chk($sformatf("rand_beat%0d", recv), 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(expb));
            recv++;
         end
         if (up) begin
            q.push_back(cur);
            sent++;
         end
         hold = m_tvalid && !m_tready;
         held = {m_tdata, m_tkeep, m_tlast, m_tuser};
         step();
         cyc++;
         if (hold) begin
            chk("stall_m_tvalid", 64'(m_tvalid), 64'd1);
            chk("stall_payload", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(held));
         end
         if (up || !s_tvalid) begin
            cur = 38'({$urandom(), 6'($urandom())});
            {s_tdata, s_tkeep, s_tlast, s_tuser} = cur;
            s_tvalid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         m_tready = 1'($urandom_range(0, 1));
      end
      chk("rand_recv_count", 64'(recv), 64'd1000);
      chk("rand_queue_empty", 64'(q.size()), 64'd0);
      s_tvalid = 1'b0; m_tready = 1'b1;
      step();
      step();

`ifdef AXIS_SKID_PKT_COUNT_EN
      do_reset(1);
      chk("cnt_reset_beat", 64'(beat_count), 64'd0);
      chk("cnt_reset_pkt", 64'(pkt_count), 64'd0);
      step();
      m_tready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'(i); s_tlast = ((i % 4) == 3);
         step();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step();
      step();
      chk("cnt_beats", 64'(beat_count), 64'd12);
      chk("cnt_pkts", 64'(pkt_count), 64'd3);
      force dut.beat_count = 32'hFFFF_FFFF;
      force dut.pkt_count  = 32'hFFFF_FFFF;
      #1;
      release dut.beat_count;
      release dut.pkt_count;
      s_tvalid = 1'b1; s_tdata = 32'h55; s_tlast = 1'b1;
      step();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step();
      step();
      chk("cnt_beat_wrap", 64'(beat_count), 64'd0);
      chk("cnt_pkt_wrap", 64'(pkt_count), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
